uart_tx_arbiter: RTL and testbench

- Shares the single UART TX line between two byte requesters.
- Arbitration is round-robin.
- Serializes each granted byte as a standard 8N1-style frame, timed by the 16x oversample tick from baud_generator (s_tick).
- Sits between baud_generator and the command/status sources that currently cannot share the TX pin.

---
 rtl/uart_tx_arbiter_if.sv | 26 ++
 rtl/uart_tx_arbiter.sv | 149 ++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 329 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_arbiter_if.sv
// Requester handshake and serial-line bundle for uart_tx_arbiter.
// master: requester/system side, slave: the arbiter itself.
interface uart_tx_arbiter_if #(
    parameter int DBIT = 8
);
    logic            req0_valid;
    logic [DBIT-1:0] req0_data;
    logic            req0_ready;
    logic            req1_valid;
    logic [DBIT-1:0] req1_data;
    logic            req1_ready;
    logic            tx;
    logic            busy;
    logic            grant_id;
    logic            tx_done_tick;

    modport master (
        output req0_valid, req0_data, req1_valid, req1_data,
        input  req0_ready, req1_ready, tx, busy, grant_id, tx_done_tick
    );

    modport slave (
        input  req0_valid, req0_data, req1_valid, req1_data,
        output req0_ready, req1_ready, tx, busy, grant_id, tx_done_tick
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Two-requester round-robin arbiter feeding a single 8N1-style UART
// transmitter, timed by the oversample tick from the baud generator.
module uart_tx_arbiter #(
    parameter int DBIT    = 8,
    parameter int OS      = 16,
    parameter int SB_TICK = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               s_tick,
    uart_tx_arbiter_if.slave   bus
);

    localparam int TMAX = (OS > SB_TICK) ? OS : SB_TICK;
    localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;
    localparam int BW   = (DBIT > 1) ? $clog2(DBIT) : 1;

    localparam logic [TW-1:0] OS_LAST  = TW'(OS - 1);
    localparam logic [TW-1:0] SB_LAST  = TW'(SB_TICK - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(DBIT - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t          state_q, state_d;
    logic [TW-1:0]   tick_q, tick_d;
    logic [BW-1:0]   bit_q, bit_d;
    logic [DBIT-1:0] shift_q, shift_d;
    logic            tx_q, tx_d;
    logic            busy_q, busy_d;
    logic            grant_q, grant_d;
    logic            last_q, last_d;
    logic            rdy0_q, rdy0_d;
    logic            rdy1_q, rdy1_d;
    logic            done_q, done_d;
    logic            gnt;

    // State and registered outputs; last_grant resets to 1 so req0 wins the first tie.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            tick_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
            grant_q <= 1'b0;
            last_q  <= 1'b1;
            rdy0_q  <= 1'b0;
            rdy1_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            tick_q  <= tick_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            rdy0_q  <= rdy0_d;
            rdy1_q  <= rdy1_d;
            done_q  <= done_d;
        end
    end

    // Arbitration, frame sequencing and next values of all registered outputs.
    always_comb begin
        state_d = state_q;
        tick_d  = tick_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        tx_d    = tx_q;
        busy_d  = busy_q;
        grant_d = grant_q;
        last_d  = last_q;
        rdy0_d  = 1'b0;
        rdy1_d  = 1'b0;
        done_d  = 1'b0;
        gnt     = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (bus.req0_valid || bus.req1_valid) begin
                    gnt     = (bus.req0_valid && bus.req1_valid) ? ~last_q : bus.req1_valid;
                    shift_d = gnt ? bus.req1_data : bus.req0_data;
                    grant_d = gnt;
                    last_d  = gnt;
                    rdy0_d  = ~gnt;
                    rdy1_d  = gnt;
                    tx_d    = 1'b0;
                    busy_d  = 1'b1;
                    tick_d  = '0;
                    state_d = START;
                end
            end
            START: begin
                if (s_tick) begin
                    if (tick_q == OS_LAST) begin
                        tick_d  = '0;
                        bit_d   = '0;
                        tx_d    = shift_q[0];
                        state_d = DATA;
                    end else begin
                        tick_d = tick_q + 1'b1;
                    end
                end
            end
            DATA: begin
                if (s_tick) begin
                    if (tick_q == OS_LAST) begin
                        tick_d = '0;
                        if (bit_q == BIT_LAST) begin
                            tx_d    = 1'b1;
                            state_d = STOP;
                        end else begin
                            // tx takes the bit that becomes shift[0] after this shift
                            shift_d = shift_q >> 1;
                            bit_d   = bit_q + 1'b1;
                            tx_d    = shift_q[1];
                        end
                    end else begin
                        tick_d = tick_q + 1'b1;
                    end
                end
            end
            STOP: begin
                if (s_tick) begin
                    if (tick_q == SB_LAST) begin
                        tick_d  = '0;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        tick_d = tick_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.tx           = tx_q;
    assign bus.busy         = busy_q;
    assign bus.grant_id     = grant_q;
    assign bus.req0_ready   = rdy0_q;
    assign bus.req1_ready   = rdy1_q;
    assign bus.tx_done_tick = done_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: table of single/dual requests, a line-level
// 8N1 receiver feeding a scoreboard, and hand sequences for timing,
// round-robin, mid-frame reset and a 2-stop-bit build.
module tb_uart_tx_arbiter;

    logic clk = 1'b0;
    logic rst;
    logic s_tick;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic       id;
        logic [7:0] d;
    } exp_t;
    exp_t exp_q[$];

    typedef struct {
        logic       v0;
        logic       v1;
        logic [7:0] d0;
        logic [7:0] d1;
        logic       first;
    } vec_t;
    vec_t tbl[7];

    uart_tx_arbiter_if #(.DBIT(8)) bus ();
    uart_tx_arbiter_if #(.DBIT(8)) bus2 ();

    uart_tx_arbiter #(.DBIT(8), .OS(16), .SB_TICK(16)) dut (
        .clk    (clk),
        .rst    (rst),
        .s_tick (s_tick),
        .bus    (bus)
    );

    uart_tx_arbiter #(.DBIT(8), .OS(16), .SB_TICK(32)) dut2 (
        .clk    (clk),
        .rst    (rst),
        .s_tick (s_tick),
        .bus    (bus2)
    );

    always #5 clk = ~clk;

    // s_tick: one-clk pulse every 4 clk
    initial begin
        s_tick = 1'b0;
        forever begin
            repeat (3) @(posedge clk);
            #1 s_tick = 1'b1;
            @(posedge clk);
            #1 s_tick = 1'b0;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic decode_frame();
        logic       ab;
        logic [7:0] dat;
        logic       st, sp, gid;
        exp_t       e;
        ab = 1'b0; dat = '0; st = 1'b1; sp = 1'b0; gid = 1'b0;
        for (int c = 1; c <= 32 + 9 * 64; c++) begin
            @(negedge clk);
            if (rst) ab = 1'b1;
            if (ab) break;
            if (c == 32) begin
                st  = bus.tx;
                gid = bus.grant_id;
            end else if (c > 32 && c < 32 + 9 * 64 && (c - 32) % 64 == 0) begin
                dat[(c - 32) / 64 - 1] = bus.tx;
            end else if (c == 32 + 9 * 64) begin
                sp = bus.tx;
            end
        end
        if (!ab) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_frame: got data %0h want no frame", dat);
            end else begin
                e = exp_q.pop_front();
                chk("frame_data", 32'(dat), 32'(e.d));
                chk("frame_grant_id", 32'(gid), 32'(e.id));
                chk("start_bit", 32'(st), 32'd0);
                chk("stop_bit", 32'(sp), 32'd1);
            end
        end
    endtask

    // Line receiver: a falling edge on an idle-high line starts a frame
    initial begin : monitor
        logic prev;
        prev = 1'b1;
        forever begin
            @(negedge clk);
            if (!rst && prev === 1'b1 && bus.tx === 1'b0) decode_frame();
            prev = rst ? 1'b1 : bus.tx;
        end
    end

    task automatic push_exp(input logic id, input logic [7:0] d);
        exp_t e;
        e.id = id;
        e.d  = d;
        exp_q.push_back(e);
    endtask

    // Present one request set, push expected frames, run handshakes to completion
    task automatic run_entry(input logic v0, input logic v1, input logic [7:0] d0,
                             input logic [7:0] d1, input logic first);
        int  r0, r1, ndone, gap;
        logic pb, fin;
        if (v0 && v1) begin
            push_exp(first, first ? d1 : d0);
            push_exp(~first, first ? d0 : d1);
        end else begin
            push_exp(first, first ? d1 : d0);
        end
        bus.req0_valid = v0; bus.req0_data = d0;
        bus.req1_valid = v1; bus.req1_data = d1;
        r0 = 0; r1 = 0; ndone = 0; gap = -1; fin = 1'b0;
        pb = bus.busy;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            @(negedge clk);
            if (bus.req0_ready) begin
                r0++;
                chk("ready0_while_busy", 32'(pb), 32'd0);
                bus.req0_valid = 1'b0;
            end
            if (bus.req1_ready) begin
                r1++;
                chk("ready1_while_busy", 32'(pb), 32'd0);
                bus.req1_valid = 1'b0;
            end
            if (gap >= 0) begin
                gap++;
                if (bus.tx === 1'b0) begin
                    chk("b2b_gap_le2", 32'(gap <= 2), 32'd1);
                    gap = -1;
                end
            end
            if (bus.tx_done_tick) begin
                ndone++;
                if (v0 && v1 && ndone == 1) gap = 0;
            end
            pb = bus.busy;
            if (!bus.req0_valid && !bus.req1_valid && !bus.busy && exp_q.size() == 0) begin
                fin = 1'b1;
                break;
            end
        end
        if (!fin) begin
            total++;
            bad++;
            $display("FAIL entry_timeout: got pending=%0d want 0", exp_q.size());
        end
        chk("ready0_count", 32'(r0), 32'(v0));
        chk("ready1_count", 32'(r1), 32'(v1));
        chk("done_count", 32'(ndone), 32'(int'(v0) + int'(v1)));
    endtask

    initial begin
        tbl[0] = '{v0: 1'b1, v1: 1'b1, d0: 8'h55, d1: 8'h0F, first: 1'b0};
        tbl[1] = '{v0: 1'b1, v1: 1'b0, d0: 8'hA5, d1: 8'h00, first: 1'b0};
        tbl[2] = '{v0: 1'b0, v1: 1'b1, d0: 8'h00, d1: 8'h3C, first: 1'b1};
        tbl[3] = '{v0: 1'b0, v1: 1'b1, d0: 8'h00, d1: 8'hC3, first: 1'b1};
        tbl[4] = '{v0: 1'b1, v1: 1'b1, d0: 8'h12, d1: 8'h34, first: 1'b0};
        tbl[5] = '{v0: 1'b1, v1: 1'b0, d0: 8'hFF, d1: 8'h00, first: 1'b0};
        tbl[6] = '{v0: 1'b1, v1: 1'b1, d0: 8'h00, d1: 8'h80, first: 1'b1};

        bus2.req0_valid = 1'b0; bus2.req0_data = '0;
        bus2.req1_valid = 1'b0; bus2.req1_data = '0;

        // Reset held 3 clk with random requests
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            bus.req0_valid = 1'($urandom); bus.req0_data = 8'($urandom);
            bus.req1_valid = 1'($urandom); bus.req1_data = 8'($urandom);
            @(negedge clk);
            chk("rst_tx", 32'(bus.tx), 32'd1);
            chk("rst_busy", 32'(bus.busy), 32'd0);
            chk("rst_grant_id", 32'(bus.grant_id), 32'd0);
            chk("rst_ready0", 32'(bus.req0_ready), 32'd0);
            chk("rst_ready1", 32'(bus.req1_ready), 32'd0);
            chk("rst_done", 32'(bus.tx_done_tick), 32'd0);
        end
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 7; i++)
            run_entry(tbl[i].v0, tbl[i].v1, tbl[i].d0, tbl[i].d1, tbl[i].first);

        // Single frame timing: done 160 ticks after first counted tick
        begin
            int k;
            logic got;
            push_exp(1'b0, 8'h81);
            bus.req0_valid = 1'b1; bus.req0_data = 8'h81;
            got = 1'b0;
            for (int c = 0; c < 50; c++) begin
                @(negedge clk);
                if (bus.req0_ready) begin got = 1'b1; break; end
            end
            chk("timing_ready_seen", 32'(got), 32'd1);
            bus.req0_valid = 1'b0;
            k = 0; got = 1'b0;
            for (int c = 0; c < 1000; c++) begin
                @(negedge clk);
                k++;
                chk("timing_no_ready", 32'(bus.req0_ready | bus.req1_ready), 32'd0);
                if (bus.tx_done_tick) begin got = 1'b1; break; end
            end
            chk("timing_done_seen", 32'(got), 32'd1);
            chk("frame_len_clk_637_640", 32'(k >= 637 && k <= 640), 32'd1);
            @(negedge clk);
            chk("done_one_cycle", 32'(bus.tx_done_tick), 32'd0);
            chk("timing_queue_empty", 32'(exp_q.size()), 32'd0);
        end

        // Reset during DATA bit 3 of a req1 frame
        begin
            logic got;
            bus.req1_valid = 1'b1; bus.req1_data = 8'h5A;
            got = 1'b0;
            for (int c = 0; c < 50; c++) begin
                @(negedge clk);
                if (bus.req1_ready) begin got = 1'b1; break; end
            end
            chk("abort_ready_seen", 32'(got), 32'd1);
            bus.req1_valid = 1'b0;
            repeat (290) @(negedge clk);
            chk("abort_busy_before", 32'(bus.busy), 32'd1);
            rst = 1'b1;
            bus.req0_valid = 1'b1; bus.req0_data = 8'h11;
            bus.req1_valid = 1'b1; bus.req1_data = 8'h22;
            @(negedge clk);
            chk("abort_tx", 32'(bus.tx), 32'd1);
            chk("abort_busy", 32'(bus.busy), 32'd0);
            for (int c = 0; c < 3; c++) begin
                chk("abort_done", 32'(bus.tx_done_tick), 32'd0);
                chk("abort_ready", 32'(bus.req0_ready | bus.req1_ready), 32'd0);
                @(negedge clk);
            end
            rst = 1'b0;
            run_entry(1'b1, 1'b1, 8'h11, 8'h22, 1'b0);
        end

        // Four frames with both requesters continuously valid
        begin
            int n0, n1;
            logic fin;
            push_exp(1'b0, 8'hC1); push_exp(1'b1, 8'hD1);
            push_exp(1'b0, 8'hC2); push_exp(1'b1, 8'hD2);
            bus.req0_valid = 1'b1; bus.req0_data = 8'hC1;
            bus.req1_valid = 1'b1; bus.req1_data = 8'hD1;
            n0 = 0; n1 = 0; fin = 1'b0;
            for (int c = 0; c < 6000; c++) begin
                @(negedge clk);
                if (bus.req0_ready) begin
                    n0++;
                    if (n0 < 2) bus.req0_data = 8'hC2; else bus.req0_valid = 1'b0;
                end
                if (bus.req1_ready) begin
                    n1++;
                    if (n1 < 2) bus.req1_data = 8'hD2; else bus.req1_valid = 1'b0;
                end
                if (!bus.req0_valid && !bus.req1_valid && !bus.busy && exp_q.size() == 0) begin
                    fin = 1'b1;
                    break;
                end
            end
            chk("rr_finished", 32'(fin), 32'd1);
            chk("rr_ready0_count", 32'(n0), 32'd2);
            chk("rr_ready1_count", 32'(n1), 32'd2);
        end

        // Two-stop-bit build: 176 ticks per frame, single accept while valid held
        begin
            int k, nr;
            logic got;
            bus2.req0_valid = 1'b1; bus2.req0_data = 8'h96;
            got = 1'b0; nr = 0;
            for (int c = 0; c < 50; c++) begin
                @(negedge clk);
                if (bus2.req0_ready) begin got = 1'b1; nr++; break; end
            end
            chk("sb32_ready_seen", 32'(got), 32'd1);
            k = 0; got = 1'b0;
            for (int c = 0; c < 1000; c++) begin
                @(negedge clk);
                k++;
                if (bus2.req0_ready) nr++;
                if (bus2.tx_done_tick) begin got = 1'b1; break; end
            end
            bus2.req0_valid = 1'b0;
            chk("sb32_done_seen", 32'(got), 32'd1);
            chk("sb32_len_clk_701_704", 32'(k >= 701 && k <= 704), 32'd1);
            @(negedge clk);
            if (bus2.req0_ready) nr++;
            chk("sb32_ready_count", 32'(nr), 32'd1);
            chk("sb32_idle_tx", 32'(bus2.tx), 32'd1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
